// File: rtl/piso_shift_ctrl_if.sv
// Load-side handshake and serial-side outputs of the PISO shifter.
interface piso_shift_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] pi;
    logic             load;
    logic             ready;
    logic             shift_en;
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;

    // Producer / line-driver side.
    modport master (
        output pi, load, shift_en,
        input  ready, so, so_valid, busy, done
    );

    // Shifter side.
    modport slave (
        input  pi, load, shift_en,
        output ready, so, so_valid, busy, done
    );
endinterface

// File: rtl/piso_shift_ctrl.sv
// Parallel-in serial-out shifter with valid/ready word load, bit-rate enable,
// frame-valid output, done pulse and gapless back-to-back reload.
module piso_shift_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    piso_shift_ctrl_if.slave         bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             done_q, done_nx;

    logic             last_bit_c;
    logic             ready_c;
    logic             accept_c;
    logic             out_bit_c;
    logic [WIDTH-1:0] shifted_c;

    // Last bit is being consumed this cycle; frees the slot for a new word.
    assign last_bit_c = (state == SHIFT) && (cnt == CW'(1)) && bus.shift_en;
    assign ready_c    = rst & ((state == IDLE) | last_bit_c);
    assign accept_c   = bus.load & ready_c;

    // Move the next bit toward the output end, zero fill behind it.
    assign shifted_c  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg[WIDTH-1:1]};
    assign out_bit_c  = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            sreg   <= sreg_nx;
            cnt    <= cnt_nx;
            done_q <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        cnt_nx   = cnt;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    sreg_nx  = bus.pi;
                    cnt_nx   = CW'(WIDTH);
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (cnt > CW'(1)) begin
                        sreg_nx = shifted_c;
                        cnt_nx  = cnt - CW'(1);
                    end else begin
                        done_nx = 1'b1;
                        if (accept_c) begin
                            sreg_nx = bus.pi;
                            cnt_nx  = CW'(WIDTH);
                        end else begin
                            sreg_nx  = shifted_c;
                            cnt_nx   = '0;
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.ready    = ready_c;
    assign bus.so       = (state == SHIFT) ? out_bit_c : IDLE_LEVEL;
    assign bus.so_valid = (state == SHIFT);
    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Directed bench for piso_shift_ctrl: three parameterisations, bit-stream scoreboard.
module tb_piso_shift_ctrl;
    logic clk;
    logic rst;

    int checks;
    int failures;
    int done4m;
    int done4l;
    int done8;

    bit q4m[$];
    bit q4l[$];
    bit q8[$];

    logic [3:0] w4;
    logic [7:0] w8;

    piso_shift_ctrl_if #(.WIDTH(4)) b4m ();
    piso_shift_ctrl_if #(.WIDTH(4)) b4l ();
    piso_shift_ctrl_if #(.WIDTH(8)) b8  ();

    piso_shift_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u4m (
        .clk(clk), .rst(rst), .bus(b4m));
    piso_shift_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u4l (
        .clk(clk), .rst(rst), .bus(b4l));
    piso_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u8 (
        .clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every consumed bit (so_valid & shift_en) must match the queue head.
    always @(negedge clk) begin
        if (b4m.so_valid === 1'b1 && b4m.shift_en === 1'b1) begin
            chkn("4m_unexpected_bit", int'(q4m.size() > 0), 1);
            if (q4m.size() > 0) chk("4m_bit", b4m.so, q4m.pop_front());
        end
        if (b4l.so_valid === 1'b1 && b4l.shift_en === 1'b1) begin
            chkn("4l_unexpected_bit", int'(q4l.size() > 0), 1);
            if (q4l.size() > 0) chk("4l_bit", b4l.so, q4l.pop_front());
        end
        if (b8.so_valid === 1'b1 && b8.shift_en === 1'b1) begin
            chkn("8_unexpected_bit", int'(q8.size() > 0), 1);
            if (q8.size() > 0) chk("8_bit", b8.so, q8.pop_front());
        end
        if (b4m.done === 1'b1) done4m++;
        if (b4l.done === 1'b1) done4l++;
        if (b8.done === 1'b1) done8++;
        chk("4m_busy_vs_valid", b4m.busy, b4m.so_valid);
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        done4m = 0; done4l = 0; done8 = 0;
        rst = 1'b0;
        b4m.pi = '0; b4m.load = 1'b0; b4m.shift_en = 1'b1;
        b4l.pi = '0; b4l.load = 1'b0; b4l.shift_en = 1'b1;
        b8.pi  = '0; b8.load  = 1'b0; b8.shift_en  = 1'b0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_ready_4m", b4m.ready, 1'b0);
        chk("rst_ready_8", b8.ready, 1'b0);
        chk("rst_so_4m", b4m.so, 1'b0);
        chk("rst_so_4l", b4l.so, 1'b1);
        chk("rst_busy_4m", b4m.busy, 1'b0);
        chk("rst_done_4m", b4m.done, 1'b0);
        step();
        rst = 1'b1;
        #1;
        chk("rel_ready_4m", b4m.ready, 1'b1);
        chk("rel_ready_4l", b4l.ready, 1'b1);
        chk("rel_ready_8", b8.ready, 1'b1);
        step();

        // MSB-first 4'b1010
        w4 = 4'b1010;
        for (int k = 3; k >= 0; k--) q4m.push_back(w4[k]);
        b4m.pi = w4; b4m.load = 1'b1;
        step();
        b4m.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_valid", b4m.so_valid, 1'b1);
            chk("t1_done_early", b4m.done, 1'b0);
        end
        @(negedge clk);
        chk("t1_valid_end", b4m.so_valid, 1'b0);
        chk("t1_done", b4m.done, 1'b1);
        chk("t1_so_idle", b4m.so, 1'b0);
        @(negedge clk);
        chk("t1_done_once", b4m.done, 1'b0);
        step();

        // LSB-first 4'b1100, idle level 1
        w4 = 4'b1100;
        for (int k = 0; k < 4; k++) q4l.push_back(w4[k]);
        b4l.pi = w4; b4l.load = 1'b1;
        step();
        b4l.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_valid", b4l.so_valid, 1'b1);
        end
        @(negedge clk);
        chk("t2_done", b4l.done, 1'b1);
        chk("t2_so_idle", b4l.so, 1'b1);
        step();

        // WIDTH=8, 8'hA5, shift_en strobes every third cycle
        w8 = 8'hA5;
        for (int k = 7; k >= 0; k--) q8.push_back(w8[k]);
        b8.pi = w8; b8.load = 1'b1; b8.shift_en = 1'b0;
        step();
        b8.load = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 3; j++) begin
                b8.shift_en = (j == 2);
                @(negedge clk);
                chk("t3_so_hold", b8.so, w8[7-b]);
                chk("t3_ready", b8.ready, (b == 7) && (j == 2));
                chk("t3_busy", b8.busy, 1'b1);
                step();
            end
        end
        b8.shift_en = 1'b0;
        @(negedge clk);
        chk("t3_done", b8.done, 1'b1);
        chk("t3_busy_end", b8.busy, 1'b0);
        step();

        // Back-to-back 4'b1001 then 4'b0110, load held
        w4 = 4'b1001;
        for (int k = 3; k >= 0; k--) q4m.push_back(w4[k]);
        w4 = 4'b0110;
        for (int k = 3; k >= 0; k--) q4m.push_back(w4[k]);
        b4m.pi = 4'b1001; b4m.load = 1'b1;
        step();
        b4m.pi = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_busy_a", b4m.busy, 1'b1);
            chk("t4_ready", b4m.ready, i == 3);
        end
        step();
        b4m.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_busy_b", b4m.busy, 1'b1);
            chk("t4_done_a", b4m.done, i == 0);
        end
        @(negedge clk);
        chk("t4_done_b", b4m.done, 1'b1);
        chk("t4_busy_end", b4m.busy, 1'b0);
        step();

        // Load while not ready is dropped
        w4 = 4'b0011;
        for (int k = 3; k >= 0; k--) q4m.push_back(w4[k]);
        b4m.pi = w4; b4m.load = 1'b1;
        step();
        b4m.pi = 4'b1111;
        @(negedge clk);
        chk("t5_ready_blk1", b4m.ready, 1'b0);
        step();
        @(negedge clk);
        chk("t5_ready_blk2", b4m.ready, 1'b0);
        step();
        b4m.load = 1'b0; b4m.pi = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("t5_ready_last", b4m.ready, 1'b1);
        @(negedge clk);
        chk("t5_done", b4m.done, 1'b1);
        chk("t5_busy", b4m.busy, 1'b0);
        chk("t5_so_idle", b4m.so, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_stay_idle", b4m.busy, 1'b0);
            chk("t5_so_idle2", b4m.so, 1'b0);
        end
        step();

        // Reset mid-frame aborts with no done
        w4 = 4'b1111;
        q4m.push_back(1'b1); q4m.push_back(1'b1);
        b4m.pi = w4; b4m.load = 1'b1;
        step();
        b4m.load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step();
        chk("t6_busy_pre", b4m.busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("t6_so", b4m.so, 1'b0);
        chk("t6_busy", b4m.busy, 1'b0);
        chk("t6_valid", b4m.so_valid, 1'b0);
        chk("t6_ready", b4m.ready, 1'b0);
        chk("t6_done", b4m.done, 1'b0);
        chk("t6_so_4l", b4l.so, 1'b1);
        chk("t6_ready_4l", b4l.ready, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_done_in_rst", b4m.done, 1'b0);
        end
        step();
        rst = 1'b1;
        #1;
        chk("t6_ready_rel", b4m.ready, 1'b1);
        repeat (6) begin
            @(negedge clk);
            chk("t6_no_done", b4m.done, 1'b0);
            chk("t6_idle", b4m.busy, 1'b0);
        end

        // Every expected bit consumed, done pulses counted
        chkn("q4m_empty", q4m.size(), 0);
        chkn("q4l_empty", q4l.size(), 0);
        chkn("q8_empty", q8.size(), 0);
        chkn("done_cnt_4m", done4m, 4);
        chkn("done_cnt_4l", done4l, 1);
        chkn("done_cnt_8", done8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/piso_shift_ctrl.md
Name: piso_shift_ctrl

Overview:
Parametrised parallel-in serial-out shifter with a valid/ready load handshake.
- Adds over the fixed 4-bit load/shift register: configurable word width and bit order, a bit-rate enable, a frame-valid output and a done pulse.
- Supports gapless back-to-back frames.
- Sits between a word-producing datapath and a serial line driver.

Parameters:
WIDTH, 8, word width in bits (legal range >= 2)
MSB_FIRST, 1, 1 = transmit pi[WIDTH-1] first; 0 = transmit pi[0] first
IDLE_LEVEL, 0, value driven on so when no frame is active

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-low reset
pi  input  WIDTH  parallel word to serialise
load  input  1  word valid; a transfer occurs when load & ready
ready  output  1  block can accept a word this cycle
shift_en  input  1  bit-rate strobe; the serial output advances one bit per clk with shift_en=1
so  output  1  serial data out
so_valid  output  1  high while so carries frame data
busy  output  1  frame in progress (equals so_valid)
done  output  1  one-cycle pulse after the last bit of a frame is consumed

Behaviour:
- Registers: shift register sreg[WIDTH-1:0], bit counter cnt of width $clog2(WIDTH+1), state IDLE/SHIFT, done flop.
- Reset (rst=0, asynchronous): state=IDLE, sreg=0, cnt=0, done=0.
  - so=IDLE_LEVEL, so_valid=busy=0.
  - ready forced 0 while rst=0; ready rises combinationally once rst=1.
  - Reset mid-frame aborts the frame immediately, with no done pulse.
- ready = rst & ((state==IDLE) | (state==SHIFT & cnt==1 & shift_en)).
- Accept (load & ready at a clk edge): sreg<=pi, cnt<=WIDTH, state<=SHIFT.
  - First bit appears on so in the cycle after the edge.
- load while ready=0 is ignored: no capture, no error; the producer must hold load.
- so selection:
  - In SHIFT: so = sreg[WIDTH-1] when MSB_FIRST=1, else sreg[0].
  - In IDLE: so = IDLE_LEVEL.
- so_valid = busy = (state==SHIFT).
- In SHIFT with shift_en=1:
  - cnt>1: sreg shifts toward the output end by one bit, zero fill; cnt decrements.
  - cnt==1 (last bit): done<=1.
    - If load=1 in the same cycle: gapless reload (sreg<=pi, cnt<=WIDTH, state stays SHIFT).
    - Otherwise: state<=IDLE, cnt<=0.
- In SHIFT with shift_en=0: all state holds and so is stable. Each bit is held for as many cycles as shift_en stays low.
- shift_en is ignored in IDLE.
- done is 1 for exactly one cycle, in the cycle after the last-bit edge; it is otherwise 0.
- Latency: a word accepted at edge N with shift_en held high gives bits on so in cycles N+1 .. N+WIDTH, and done in cycle N+WIDTH+1.
- Throughput: one word per WIDTH shift_en strobes, with no idle bit between frames.
- No overflow condition exists: the handshake is the only flow control.

Test Plan:
- Reset: drive rst=0 mid-frame with WIDTH=4 -> so=IDLE_LEVEL, busy=0, ready=0, done=0 immediately. After rst=1: ready=1, no done pulse.
- WIDTH=4, MSB_FIRST=1: load pi=4'b1010 with shift_en=1 every cycle -> so=1,0,1,0 over 4 cycles; so_valid high for those 4 cycles only; done high in cycle 5.
- WIDTH=4, MSB_FIRST=0: load pi=4'b1100 -> so=0,0,1,1; done pulses once.
- shift_en low 2 cycles per bit, WIDTH=8, pi=8'hA5 -> each bit is held 3 cycles; sequence 1,0,1,0,0,1,0,1; ready=0 until the last-bit strobe.
- Back-to-back: load 4'b1001 then hold load=1 with pi=4'b0110 -> second word is accepted on the last-bit edge; so=1,0,0,1,0,1,1,0 with no gap; busy never drops; two done pulses.
- Blocked load: assert load with pi=4'b1111 mid-frame (ready=0), deassert before the last bit -> word is never captured; so returns to IDLE_LEVEL after the frame.
